fft8_stage_ctrl: RTL and testbench

- Sequencer for the 8-point in-place radix-2 DIT FFT in the audio front end.
- Loads 8 samples into the working RAM in bit-reversed order, then steps through 3 butterfly stages of 4 butterflies each.
- Drives RAM read/write addresses and the 3-bit twiddle index consumed by the 8-entry twiddle ROM (entry k = W8^k).
- Holds no data. Only control, addresses and status.

---
 rtl/fft8_stage_ctrl_if.sv | 39 +++
 rtl/fft8_stage_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_fft8_stage_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft8_stage_ctrl_if.sv
// Handshake and RAM/ROM control bundle of the 8-point FFT sequencer.
//   master : the sequencer (drives ready, strobes, addresses, status)
//   slave  : the surrounding datapath (drives start and in_valid)
interface fft8_stage_ctrl_if;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned STAGE_W = 2;

    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic               load_wr_en;
    logic [ADDR_W-1:0]  load_addr;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  rd_addr_a;
    logic [ADDR_W-1:0]  rd_addr_b;
    logic [ADDR_W-1:0]  tw_index;
    logic               mem_wr_en;
    logic [ADDR_W-1:0]  wr_addr_a;
    logic [ADDR_W-1:0]  wr_addr_b;
    logic [STAGE_W-1:0] stage;
    logic               busy;
    logic               done;

    modport master (
        input  start, in_valid,
        output in_ready, load_wr_en, load_addr,
        output mem_rd_en, rd_addr_a, rd_addr_b, tw_index,
        output mem_wr_en, wr_addr_a, wr_addr_b,
        output stage, busy, done
    );

    modport slave (
        output start, in_valid,
        input  in_ready, load_wr_en, load_addr,
        input  mem_rd_en, rd_addr_a, rd_addr_b, tw_index,
        input  mem_wr_en, wr_addr_a, wr_addr_b,
        input  stage, busy, done
    );
endinterface

// File: rtl/fft8_stage_ctrl.sv
// Sequencer for an 8-point in-place radix-2 DIT FFT.
// Loads 8 samples in bit-reversed order, then issues 3 stages x 4 butterflies
// of RAM reads with twiddle indices; write-backs follow each read by BF_LAT.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - fft8_stage_ctrl_if.master: start/in_valid in; in_ready, load
//          strobe/address, read/twiddle, write-back, stage, busy, done out
// BF_LAT (1..4): cycles from mem_rd_en to the matching mem_wr_en.
module fft8_stage_ctrl #(
    parameter int unsigned BF_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    fft8_stage_ctrl_if.master  bus
);

    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned STAGE_W   = 2;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned LAST_STG  = 2;
    localparam int unsigned LAST_BF   = 3;
    localparam int unsigned LAST_LOAD = 7;
    localparam int unsigned LAST_DRN  = BF_LAT - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
    } wb_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STAGE_W-1:0] stage_q, stage_d;

    logic               in_ready_c;
    logic               load_wr_en_c;
    logic [ADDR_W-1:0]  load_addr_c;
    logic               rd_en_c;
    logic [ADDR_W-1:0]  rd_a_c;
    logic [ADDR_W-1:0]  rd_b_c;
    logic [ADDR_W-1:0]  tw_c;

    logic [ADDR_W-1:0]  j_c;
    logic [ADDR_W-1:0]  half_c;
    logic [ADDR_W-1:0]  grp_c;
    logic [ADDR_W-1:0]  p_c;
    logic [ADDR_W-1:0]  base_c;

    wb_t                pipe_q [BF_LAT];

    // State, shared phase counter and stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
        end
    end

    // Next state; cnt_q counts samples in LOAD, butterflies in RUN and
    // latency cycles in DRAIN, and is cleared on every phase change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                stage_d = '0;
                if (bus.start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    if (cnt_q == CNT_W'(LAST_LOAD)) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        stage_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(LAST_BF)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(LAST_DRN)) begin
                    cnt_d = '0;
                    if (stage_q == STAGE_W'(LAST_STG)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RUN;
                        stage_d = stage_q + STAGE_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                stage_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                stage_d = '0;
            end
        endcase
    end

    // Load strobe/address and butterfly read addressing, decoded from
    // the registered state, counter and stage.
    always_comb begin
        in_ready_c   = 1'b0;
        load_wr_en_c = 1'b0;
        load_addr_c  = '0;
        rd_en_c      = 1'b0;
        rd_a_c       = '0;
        rd_b_c       = '0;
        tw_c         = '0;

        j_c    = ADDR_W'(cnt_q[1:0]);
        half_c = ADDR_W'(1) << stage_q;
        grp_c  = j_c >> stage_q;
        p_c    = j_c & (half_c - ADDR_W'(1));
        // grp * 2 * half: groups are 2*half words apart.
        base_c = ADDR_W'(grp_c << (stage_q + STAGE_W'(1)));

        if (state_q == S_LOAD) begin
            in_ready_c   = 1'b1;
            load_wr_en_c = bus.in_valid;
            load_addr_c  = {cnt_q[0], cnt_q[1], cnt_q[2]};
        end

        if (state_q == S_RUN) begin
            rd_en_c = 1'b1;
            rd_a_c  = base_c + p_c;
            rd_b_c  = base_c + p_c + half_c;
            tw_c    = ADDR_W'(p_c << (STAGE_W'(LAST_STG) - stage_q));
        end
    end

    // Write-back delay line: a read issued in cycle c writes in c+BF_LAT.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BF_LAT); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{en: rd_en_c, a: rd_a_c, b: rd_b_c};
            for (int i = 1; i < int'(BF_LAT); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.load_wr_en = load_wr_en_c;
    assign bus.load_addr  = load_addr_c;
    assign bus.mem_rd_en  = rd_en_c;
    assign bus.rd_addr_a  = rd_a_c;
    assign bus.rd_addr_b  = rd_b_c;
    assign bus.tw_index   = tw_c;
    assign bus.mem_wr_en  = pipe_q[BF_LAT-1].en;
    assign bus.wr_addr_a  = pipe_q[BF_LAT-1].a;
    assign bus.wr_addr_b  = pipe_q[BF_LAT-1].b;
    assign bus.stage      = stage_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_FIN);

endmodule

// File: tb/tb_fft8_stage_ctrl.sv
// Directed bench for fft8_stage_ctrl: three instances (BF_LAT 1, 2, 4)
// share clk/rst/start/in_valid; the BF_LAT=2 instance is traced in detail.
module tb_fft8_stage_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic in_valid;

    always #5 clk = ~clk;

    fft8_stage_ctrl_if b1 ();
    fft8_stage_ctrl_if b2 ();
    fft8_stage_ctrl_if b4 ();

    assign b1.start = start;
    assign b2.start = start;
    assign b4.start = start;
    assign b1.in_valid = in_valid;
    assign b2.in_valid = in_valid;
    assign b4.in_valid = in_valid;

    fft8_stage_ctrl #(.BF_LAT(1)) u_lat1 (.clk(clk), .rst(rst), .bus(b1));
    fft8_stage_ctrl #(.BF_LAT(2)) u_lat2 (.clk(clk), .rst(rst), .bus(b2));
    fft8_stage_ctrl #(.BF_LAT(4)) u_lat4 (.clk(clk), .rst(rst), .bus(b4));

    typedef struct {
        int         cyc;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] tw;
    } ev_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed tables for the BF_LAT=2 instance.
    logic [2:0] exp_ld [8]  = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    logic [2:0] exp_a  [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0] exp_b  [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0] exp_tw [12] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3};

    // Trace of the BF_LAT=2 instance plus done times of all three.
    ev_t        rd_q [$];
    ev_t        wr_q [$];
    logic [2:0] ld_q [$];
    int         last_hs = -100;
    int         done1 = -100;
    int         done2 = -100;
    int         done4 = -100;
    int         done_n = 0;
    bit         done4_seen = 1'b0;
    logic       busy_after = 1'bx;
    logic       rdy_after = 1'bx;
    logic [1:0] st_done = 2'bxx;
    logic [1:0] st_after = 2'bxx;
    bit         clr_req = 1'b0;

    always @(negedge clk) begin
        if (clr_req) begin
            rd_q.delete();
            wr_q.delete();
            ld_q.delete();
            last_hs    <= -100;
            done1      <= -100;
            done2      <= -100;
            done4      <= -100;
            done_n     <= 0;
            done4_seen <= 1'b0;
            busy_after <= 1'bx;
            rdy_after  <= 1'bx;
            st_done    <= 2'bxx;
            st_after   <= 2'bxx;
        end else begin
            if (b2.load_wr_en) begin
                ld_q.push_back(b2.load_addr);
                last_hs <= cyc;
            end
            if (b2.mem_rd_en) rd_q.push_back('{cyc, b2.rd_addr_a, b2.rd_addr_b, b2.tw_index});
            if (b2.mem_wr_en) wr_q.push_back('{cyc, b2.wr_addr_a, b2.wr_addr_b, 3'd0});
            if (b2.done) begin
                done2   <= cyc;
                done_n  <= done_n + 1;
                st_done <= b2.stage;
            end
            if (cyc == done2 + 1) begin
                busy_after <= b2.busy;
                st_after   <= b2.stage;
            end
            if (cyc == last_hs + 1) rdy_after <= b2.in_ready;
            if (b1.done) done1 <= cyc;
            if (b4.done) begin
                done4      <= cyc;
                done4_seen <= 1'b1;
            end
        end
    end

    task automatic clear_trace;
        @(posedge clk); #1 clr_req = 1'b1;
        @(negedge clk); #1 clr_req = 1'b0;
    endtask

    // Start a frame, load 8 samples, optionally poke start during RUN,
    // then wait (bounded) for the slowest instance to finish.
    task automatic run_frame(input bit gapped, input bit poke);
        int hs;
        int k;
        clear_trace();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        hs = 0;
        k = 0;
        while (hs < 8 && k < 64) begin
            in_valid = !gapped || (k % 2 == 0);
            if (in_valid && b2.in_ready) hs++;
            k++;
            @(posedge clk); #1;
        end
        checks++;
        if (hs !== 8) begin
            errors++;
            $display("FAIL load_handshakes: got %0d want 8", hs);
        end
        in_valid = !gapped;
        if (poke) begin
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1 start = 1'b0;
        end
        k = 0;
        while (!done4_seen && k < 150) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (!done4_seen) begin
            errors++;
            $display("FAIL frame_timeout: no done within 150 cycles");
        end
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [25:0] outs;
        rst = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        outs = {b2.in_ready, b2.load_wr_en, b2.load_addr, b2.mem_rd_en, b2.rd_addr_a,
                b2.rd_addr_b, b2.tw_index, b2.mem_wr_en, b2.wr_addr_a, b2.wr_addr_b,
                b2.stage, b2.busy, b2.done};
        checks++;
        if (outs !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        outs = {b2.in_ready, b2.load_wr_en, b2.load_addr, b2.mem_rd_en, b2.rd_addr_a,
                b2.rd_addr_b, b2.tw_index, b2.mem_wr_en, b2.wr_addr_a, b2.wr_addr_b,
                b2.stage, b2.busy, b2.done};
        checks++;
        if (outs !== 26'd0) begin
            errors++;
            $display("FAIL idle_outputs_with_in_valid: got %h want 0", outs);
        end
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if ({b2.busy, b2.in_ready} !== 2'b11) begin
            errors++;
            $display("FAIL start_to_load: busy,in_ready got %b want 11", {b2.busy, b2.in_ready});
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        checks++;
        if (b2.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_from_load: busy got %b want 0", b2.busy);
        end
    endtask

    task automatic check_frame(input string tag);
        int ec;
        checks++;
        if (ld_q.size() !== 8) begin
            errors++;
            $display("FAIL %s load_count: got %0d want 8", tag, ld_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (ld_q[i] !== exp_ld[i]) begin
                    errors++;
                    $display("FAIL %s load_addr[%0d]: got %0d want %0d", tag, i, ld_q[i], exp_ld[i]);
                end
            end
        end
        checks++;
        if (rd_q.size() !== 12 || wr_q.size() !== 12) begin
            errors++;
            $display("FAIL %s rd_wr_count: got %0d/%0d want 12/12", tag, rd_q.size(), wr_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                ec = last_hs + 1 + (i / 4) * 6 + (i % 4);
                checks++;
                if ({rd_q[i].a, rd_q[i].b, rd_q[i].tw} !== {exp_a[i], exp_b[i], exp_tw[i]} ||
                    rd_q[i].cyc !== ec) begin
                    errors++;
                    $display("FAIL %s read[%0d]: got a=%0d b=%0d tw=%0d @%0d want a=%0d b=%0d tw=%0d @%0d",
                             tag, i, rd_q[i].a, rd_q[i].b, rd_q[i].tw, rd_q[i].cyc,
                             exp_a[i], exp_b[i], exp_tw[i], ec);
                end
                checks++;
                if ({wr_q[i].a, wr_q[i].b} !== {exp_a[i], exp_b[i]} || wr_q[i].cyc !== ec + 2) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got a=%0d b=%0d @%0d want a=%0d b=%0d @%0d",
                             tag, i, wr_q[i].a, wr_q[i].b, wr_q[i].cyc, exp_a[i], exp_b[i], ec + 2);
                end
            end
            checks++;
            if (!(rd_q[4].cyc > wr_q[3].cyc && rd_q[8].cyc > wr_q[7].cyc)) begin
                errors++;
                $display("FAIL %s raw_hazard: next-stage read at %0d/%0d not after write %0d/%0d",
                         tag, rd_q[4].cyc, rd_q[8].cyc, wr_q[3].cyc, wr_q[7].cyc);
            end
        end
        checks++;
        if (done2 - last_hs !== 19) begin
            errors++;
            $display("FAIL %s done_lat2: got t+%0d want t+19", tag, done2 - last_hs);
        end
        checks++;
        if (done_n !== 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d want 1", tag, done_n);
        end
        checks++;
        if (busy_after !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_done: got %b want 0", tag, busy_after);
        end
    endtask

    task automatic test_load_run;
        run_frame(1'b0, 1'b0);
        check_frame("cont");
        checks++;
        if (rdy_after !== 1'b0) begin
            errors++;
            $display("FAIL in_ready_after_load: got %b want 0", rdy_after);
        end
        checks++;
        if (st_done !== 2'd2 || st_after !== 2'd0) begin
            errors++;
            $display("FAIL stage_fin_idle: got %0d/%0d want 2/0", st_done, st_after);
        end
        checks++;
        if (done1 - last_hs !== 16) begin
            errors++;
            $display("FAIL done_lat1: got t+%0d want t+16", done1 - last_hs);
        end
        checks++;
        if (done4 - last_hs !== 25) begin
            errors++;
            $display("FAIL done_lat4: got t+%0d want t+25", done4 - last_hs);
        end
    endtask

    task automatic test_gapped;
        run_frame(1'b1, 1'b1);
        check_frame("gap");
        checks++;
        if (b2.busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_run_ignored: busy got %b want 0", b2.busy);
        end
    endtask

    task automatic test_reset_mid;
        int k;
        int n0;
        clear_trace();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!(b2.stage == 2'd1 && b2.mem_rd_en) && k < 80) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 80) begin
            errors++;
            $display("FAIL reach_stage1: timeout");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({b2.mem_wr_en, b2.mem_rd_en, b2.busy, b2.in_ready, b2.done, b2.stage} !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_frame: wr,rd,busy,rdy,done,stage got %b want 0",
                     {b2.mem_wr_en, b2.mem_rd_en, b2.busy, b2.in_ready, b2.done, b2.stage});
        end
        rst = 1'b0;
        in_valid = 1'b0;
        n0 = wr_q.size();
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (wr_q.size() !== n0 || b2.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: writes got %0d want %0d, busy %b", wr_q.size(), n0, b2.busy);
        end
        run_frame(1'b0, 1'b0);
        check_frame("after_rst");
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        test_reset();
        test_load_run();
        test_gapped();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
